// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared widths, ownership and sequencer state types for sdram_arbiter
package sdram_arb_pkg;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} own_t;
  typedef enum logic {ST_SYNC, ST_RUN} st_t;
endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: port A (video read), port B (cpu read/write) and sdram controller signals
// slave modport: arbiter side; master modport: clients and controller side
interface sdram_arbiter_if #(
  parameter int ADDR_W = sdram_arb_pkg::ADDR_W,
  parameter int DATA_W = sdram_arb_pkg::DATA_W
);
  logic              a_req;
  logic [ADDR_W-1:0] a_address;
  logic              a_ack;
  logic [DATA_W-1:0] a_out;
  logic              b_req;
  logic [ADDR_W-1:0] b_address;
  logic [DATA_W-1:0] b_in;
  logic              b_we;
  logic              b_ack;
  logic [DATA_W-1:0] b_out;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_we;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_out;
  modport slave (
    input  a_req, a_address, b_req, b_address, b_in, b_we, mem_ready, mem_out,
    output a_ack, a_out, b_ack, b_out, mem_address, mem_in, mem_we
  );
  modport master (
    output a_req, a_address, b_req, b_address, b_in, b_we, mem_ready, mem_out,
    input  a_ack, a_out, b_ack, b_out, mem_address, mem_in, mem_we
  );
endinterface

// File: rtl/sdram_arb_port.sv
// sdram_arb_port: per-port ack pulse, read-data register and optional ack counter
// ports: clock, reset_n, done_i (access completes), load_i (capture data_i), ack_o, out_o
// SDRAM_ARB_STAT_EN adds stat_o, a wrapping 16-bit ack count
module sdram_arb_port #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              done_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] out_o
`ifdef SDRAM_ARB_STAT_EN
  ,
  output logic [15:0]       stat_o
`endif
);
  logic              ack_q;
  logic [DATA_W-1:0] out_q, out_d;
  assign out_d = load_i ? data_i : out_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      out_q <= '0;
    end else begin
      ack_q <= done_i;
      out_q <= out_d;
    end
  end
  assign ack_o = ack_q;
  assign out_o = out_q;
`ifdef SDRAM_ARB_STAT_EN
  logic [15:0] stat_q, stat_d;
  assign stat_d = stat_q + 16'(done_i);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stat_q <= '0;
    else stat_q <= stat_d;
  end
  assign stat_o = stat_q;
`endif
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-client front end that launches one sdram access per controller ready pulse
// ports: clock, reset_n, bus (sdram_arbiter_if.slave: client A/B handshakes and controller side)
// SDRAM_ARB_STAT_EN adds stat_a/stat_b ack counters
module sdram_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  sdram_arbiter_if.slave   bus
`ifdef SDRAM_ARB_STAT_EN
  ,
  output logic [15:0]      stat_a,
  output logic [15:0]      stat_b
`endif
);
  import sdram_arb_pkg::*;
  st_t               st_q, st_d;
  own_t              own_q, own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              a_done, b_done, launch_a, launch_b;
  // the port completing at this edge still holds req high, so it sits out this launch
  always_comb begin
    a_done   = bus.mem_ready && st_q == ST_RUN && own_q == OWN_A;
    b_done   = bus.mem_ready && st_q == ST_RUN && own_q == OWN_B;
    launch_a = bus.mem_ready && bus.a_req && !a_done;
    launch_b = bus.mem_ready && !launch_a && bus.b_req && !b_done;
    st_d     = bus.mem_ready ? ST_RUN : st_q;
    own_d    = bus.mem_ready ? (launch_a ? OWN_A : launch_b ? OWN_B : OWN_NONE) : own_q;
    addr_d   = launch_a ? bus.a_address : launch_b ? bus.b_address : addr_q;
    din_d    = launch_b ? bus.b_in : din_q;
    we_d     = bus.mem_ready ? (launch_b && bus.b_we) : we_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= ST_SYNC;
      own_q  <= OWN_NONE;
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      own_q  <= own_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      we_q   <= we_d;
    end
  end
  assign bus.mem_address = addr_q;
  assign bus.mem_in      = din_q;
  assign bus.mem_we      = we_q;
  sdram_arb_port #(.DATA_W(DATA_W)) u_a (
    .clock   (clock),
    .reset_n (reset_n),
    .done_i  (a_done),
    .load_i  (a_done),
    .data_i  (bus.mem_out),
    .ack_o   (bus.a_ack),
    .out_o   (bus.a_out)
`ifdef SDRAM_ARB_STAT_EN
    ,
    .stat_o  (stat_a)
`endif
  );
  // we_q still describes the completing access, so writes leave b_out untouched
  sdram_arb_port #(.DATA_W(DATA_W)) u_b (
    .clock   (clock),
    .reset_n (reset_n),
    .done_i  (b_done),
    .load_i  (b_done && !we_q),
    .data_i  (bus.mem_out),
    .ack_o   (bus.b_ack),
    .out_o   (bus.b_out)
`ifdef SDRAM_ARB_STAT_EN
    ,
    .stat_o  (stat_b)
`endif
  );
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter with a pulsed controller model
module tb_sdram_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  sdram_arbiter_if bus ();
`ifdef SDRAM_ARB_STAT_EN
  logic [15:0] stat_a, stat_b;
`endif
  sdram_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef SDRAM_ARB_STAT_EN
    ,
    .stat_a  (stat_a),
    .stat_b  (stat_b)
`endif
  );
  int passed = 0;
  int total = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_bout = 8'h00;
  logic [7:0] e;
  logic aa, ba, st;
  function automatic logic [7:0] f(input logic [25:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction
  task automatic pulse(input logic [7:0] d, output logic oa, output logic ob, output logic os);
    @(negedge clock);
    bus.mem_out = d;
    bus.mem_ready = 1'b1;
    @(negedge clock);
    bus.mem_ready = 1'b0;
    oa = bus.a_ack;
    ob = bus.b_ack;
    @(negedge clock);
    os = bus.a_ack | bus.b_ack;
    @(negedge clock);
  endtask
  task automatic test_reset();
    bus.a_req = 0; bus.a_address = '0; bus.b_req = 0; bus.b_address = '0;
    bus.b_in = '0; bus.b_we = 0; bus.mem_ready = 0; bus.mem_out = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (bus.mem_address !== 26'h0) $display("FAIL reset_addr got %0h exp 0", bus.mem_address); else passed++;
    total++; if (bus.mem_in !== 8'h0) $display("FAIL reset_in got %0h exp 0", bus.mem_in); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_we got %0b exp 0", bus.mem_we); else passed++;
    total++; if ({bus.a_ack, bus.b_ack} !== 2'b00) $display("FAIL reset_ack got %0b exp 00", {bus.a_ack, bus.b_ack}); else passed++;
    total++; if (bus.a_out !== 8'h0) $display("FAIL reset_aout got %0h exp 0", bus.a_out); else passed++;
    total++; if (bus.b_out !== 8'h0) $display("FAIL reset_bout got %0h exp 0", bus.b_out); else passed++;
    reset_n = 1'b1;
    @(negedge clock);
  endtask
  task automatic test_single_read();
    bus.a_address = 26'hA234;
    bus.a_req = 1'b1;
    qa.push_back(8'h55);
    pulse(8'h00, aa, ba, st);
    total++; if ({aa, ba} !== 2'b00) $display("FAIL sync_noack got %0b exp 00", {aa, ba}); else passed++;
    total++; if (bus.mem_address !== 26'hA234) $display("FAIL sync_launch_addr got %0h exp a234", bus.mem_address); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL sync_launch_we got %0b exp 0", bus.mem_we); else passed++;
    pulse(8'h55, aa, ba, st);
    bus.a_req = 1'b0;
    total++; if ({aa, ba} !== 2'b10) $display("FAIL read_ack got %0b exp 10", {aa, ba}); else passed++;
    e = qa.pop_front();
    total++; if (bus.a_out !== e) $display("FAIL read_aout got %0h exp %0h", bus.a_out, e); else passed++;
    total++; if (st !== 1'b0) $display("FAIL read_ack_width got %0b exp 0", st); else passed++;
  endtask
  task automatic test_b_write();
    bus.b_address = 26'h10; bus.b_in = 8'h3C; bus.b_we = 1'b1; bus.b_req = 1'b1;
    pulse(f(bus.mem_address), aa, ba, st);
    total++; if (bus.mem_we !== 1'b1) $display("FAIL wr_we got %0b exp 1", bus.mem_we); else passed++;
    total++; if (bus.mem_in !== 8'h3C) $display("FAIL wr_in got %0h exp 3c", bus.mem_in); else passed++;
    total++; if (bus.mem_address !== 26'h10) $display("FAIL wr_addr got %0h exp 10", bus.mem_address); else passed++;
    total++; if ({aa, ba} !== 2'b00) $display("FAIL wr_early_ack got %0b exp 00", {aa, ba}); else passed++;
    pulse(f(bus.mem_address), aa, ba, st);
    bus.b_req = 1'b0;
    total++; if ({aa, ba} !== 2'b01) $display("FAIL wr_ack got %0b exp 01", {aa, ba}); else passed++;
    total++; if (bus.b_out !== exp_bout) $display("FAIL wr_bout got %0h exp %0h", bus.b_out, exp_bout); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL wr_we_end got %0b exp 0", bus.mem_we); else passed++;
  endtask
  task automatic test_b_read();
    bus.b_address = 26'h77; bus.b_we = 1'b0; bus.b_req = 1'b1;
    qb.push_back(f(26'h77));
    pulse(f(bus.mem_address), aa, ba, st);
    pulse(f(bus.mem_address), aa, ba, st);
    bus.b_req = 1'b0;
    total++; if ({aa, ba} !== 2'b01) $display("FAIL rd_b_ack got %0b exp 01", {aa, ba}); else passed++;
    e = qb.pop_front();
    exp_bout = e;
    total++; if (bus.b_out !== e) $display("FAIL rd_bout got %0h exp %0h", bus.b_out, e); else passed++;
  endtask
  task automatic test_alternate();
    int na, nb;
    logic [25:0] pre_a, pre_b;
    na = 0; nb = 0;
    bus.a_address = 26'h100; bus.b_address = 26'h200; bus.b_we = 1'b0;
    qa.push_back(f(26'h100)); qb.push_back(f(26'h200));
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pre_a = bus.a_address;
      pre_b = bus.b_address;
      pulse(f(bus.mem_address), aa, ba, st);
      if (i < 8) begin
        total++;
        if (bus.mem_address !== ((i % 2 == 0) ? pre_a : pre_b))
          $display("FAIL alt_launch_%0d got %0h exp %0h", i, bus.mem_address, (i % 2 == 0) ? pre_a : pre_b);
        else passed++;
      end
      total++; if (aa && ba) $display("FAIL alt_coincident_%0d got 11 exp not both", i); else passed++;
      if (aa) begin
        na++;
        e = qa.pop_front();
        total++; if (bus.a_out !== e) $display("FAIL alt_aout_%0d got %0h exp %0h", i, bus.a_out, e); else passed++;
        if (na == 4) bus.a_req = 1'b0;
        else begin bus.a_address = bus.a_address + 1; qa.push_back(f(bus.a_address)); end
      end
      if (ba) begin
        nb++;
        e = qb.pop_front();
        total++; if (bus.b_out !== e) $display("FAIL alt_bout_%0d got %0h exp %0h", i, bus.b_out, e); else passed++;
        if (nb == 4) bus.b_req = 1'b0;
        else begin bus.b_address = bus.b_address + 1; qb.push_back(f(bus.b_address)); end
      end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    total++; if (na != 4) $display("FAIL alt_a_count got %0d exp 4", na); else passed++;
    total++; if (nb != 4) $display("FAIL alt_b_count got %0d exp 4", nb); else passed++;
`ifdef SDRAM_ARB_STAT_EN
    total++; if (stat_a !== 16'd5) $display("FAIL stat_a got %0d exp 5", stat_a); else passed++;
    total++; if (stat_b !== 16'd6) $display("FAIL stat_b got %0d exp 6", stat_b); else passed++;
`endif
  endtask
  task automatic test_idle();
    logic [25:0] held;
    held = bus.mem_address;
    for (int i = 0; i < 5; i++) begin
      pulse(f(bus.mem_address), aa, ba, st);
      total++; if (bus.mem_we !== 1'b0) $display("FAIL idle_we_%0d got %0b exp 0", i, bus.mem_we); else passed++;
      total++; if (bus.mem_address !== held) $display("FAIL idle_addr_%0d got %0h exp %0h", i, bus.mem_address, held); else passed++;
      total++; if ({aa, ba, st} !== 3'b000) $display("FAIL idle_ack_%0d got %0b exp 000", i, {aa, ba, st}); else passed++;
    end
  endtask
  task automatic test_reset_mid();
    bus.b_address = 26'h44; bus.b_in = 8'h99; bus.b_we = 1'b1; bus.b_req = 1'b1;
    pulse(f(bus.mem_address), aa, ba, st);
    total++; if (bus.mem_we !== 1'b1) $display("FAIL rst_mid_launch got %0b exp 1", bus.mem_we); else passed++;
    reset_n = 1'b0;
    @(negedge clock);
    total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mid_we got %0b exp 0", bus.mem_we); else passed++;
    total++; if (bus.mem_address !== 26'h0) $display("FAIL rst_mid_addr got %0h exp 0", bus.mem_address); else passed++;
    reset_n = 1'b1;
    bus.b_req = 1'b0;
    exp_bout = 8'h00;
    pulse(f(bus.mem_address), aa, ba, st);
    total++; if ({aa, ba, st} !== 3'b000) $display("FAIL rst_mid_noack got %0b exp 000", {aa, ba, st}); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mid_sync_we got %0b exp 0", bus.mem_we); else passed++;
    total++; if (bus.b_out !== exp_bout) $display("FAIL rst_mid_bout got %0h exp %0h", bus.b_out, exp_bout); else passed++;
    bus.a_address = 26'h3; bus.a_req = 1'b1;
    qa.push_back(f(26'h3));
    pulse(f(bus.mem_address), aa, ba, st);
    pulse(f(bus.mem_address), aa, ba, st);
    bus.a_req = 1'b0;
    total++; if ({aa, ba} !== 2'b10) $display("FAIL rst_recover_ack got %0b exp 10", {aa, ba}); else passed++;
    e = qa.pop_front();
    total++; if (bus.a_out !== e) $display("FAIL rst_recover_aout got %0h exp %0h", bus.a_out, e); else passed++;
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_b_write();
    test_b_read();
    test_alternate();
    test_idle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
